// File: rtl/microwave_multi_btn_debounce.sv
// N-channel pushbutton conditioner: 2-FF sync, tick-integrating debounce, edge pulses, long-press/auto-repeat.
// Outputs are registered; pulses appear the clk after the qualifying tick edge. No backpressure.
module microwave_multi_btn_debounce #(
  parameter int NUM_BTN    = 5,
  parameter int TICK_DIV   = 100000,
  parameter int STABLE_CNT = 20,
  parameter int LONG_CNT   = 1000,
  parameter int REPEAT_CNT = 200,
  parameter int REPEAT_EN  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] noise_btn,
  output logic [NUM_BTN-1:0] clean_btn,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse
);

  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STB_W    = $clog2(STABLE_CNT + 1);
  localparam int HOLD_MAX = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(STABLE_CNT - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CNT - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CNT - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, LONG, REPEAT} state_t;

  logic [DIV_W-1:0]                div_q;
  logic                            tick;
  logic [NUM_BTN-1:0]              meta_q, sync_q;
  logic [NUM_BTN-1:0][STB_W-1:0]   stb_q, stb_d;
  logic [NUM_BTN-1:0]              flip;
  logic [NUM_BTN-1:0]              clean_q, press_q, release_q, long_q, rep_q;
  logic [NUM_BTN-1:0][HOLD_W-1:0]  hold_q;
  state_t [NUM_BTN-1:0]            state_q;

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= noise_btn;
      sync_q <= meta_q;
    end
  end

  // Integrator: the clean level flips only after STABLE_CNT consecutive disagreeing ticks.
  always_comb begin
    stb_d = stb_q;
    flip  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (tick) begin
        if (sync_q[i] != clean_q[i]) begin
          if (stb_q[i] == STB_LAST) begin
            flip[i]  = 1'b1;
            stb_d[i] = '0;
          end else begin
            stb_d[i] = stb_q[i] + STB_W'(1);
          end
        end else begin
          stb_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stb_q     <= '0;
      clean_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      stb_q     <= stb_d;
      clean_q   <= clean_q ^ flip;
      press_q   <= flip & ~clean_q;
      release_q <= flip & clean_q;
    end
  end

  // A falling edge wins over any threshold hit on the same tick, so no long/repeat accompanies a release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      long_q <= '0;
      rep_q  <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= IDLE;
        hold_q[i]  <= '0;
      end
    end else begin
      long_q <= '0;
      rep_q  <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (flip[i] && clean_q[i]) begin
          state_q[i] <= IDLE;
          hold_q[i]  <= '0;
        end else if (flip[i]) begin
          state_q[i] <= PRESSED;
          hold_q[i]  <= '0;
        end else if (tick) begin
          case (state_q[i])
            PRESSED: begin
              if (hold_q[i] == LONG_LAST) begin
                long_q[i]  <= 1'b1;
                hold_q[i]  <= '0;
                state_q[i] <= LONG;
              end else begin
                hold_q[i] <= hold_q[i] + HOLD_W'(1);
              end
            end
            LONG, REPEAT: begin
              if (REPEAT_EN != 0) begin
                if (hold_q[i] == REP_LAST) begin
                  rep_q[i]   <= 1'b1;
                  hold_q[i]  <= '0;
                  state_q[i] <= REPEAT;
                end else begin
                  hold_q[i] <= hold_q[i] + HOLD_W'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign clean_btn     = clean_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = rep_q;

endmodule

// File: tb/tb_microwave_multi_btn_debounce.sv
// Random button stimulus on two instances (auto-repeat on / off) compared cycle by cycle
// against a tick-counting reference model.
module tb_microwave_multi_btn_debounce;

  localparam int NB   = 2;
  localparam int DIV  = 4;
  localparam int STB  = 3;
  localparam int LONG = 10;
  localparam int REP  = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NB-1:0] noise_btn;
  logic [NB-1:0] clean0, press0, rel0, long0, rep0;
  logic [NB-1:0] clean1, press1, rel1, long1, rep1;

  always #5 clk = ~clk;

  microwave_multi_btn_debounce #(
    .NUM_BTN(NB), .TICK_DIV(DIV), .STABLE_CNT(STB),
    .LONG_CNT(LONG), .REPEAT_CNT(REP), .REPEAT_EN(1)
  ) dut_rep (
    .clk(clk), .reset_n(reset_n), .noise_btn(noise_btn),
    .clean_btn(clean0), .press_pulse(press0), .release_pulse(rel0),
    .long_pulse(long0), .repeat_pulse(rep0)
  );

  microwave_multi_btn_debounce #(
    .NUM_BTN(NB), .TICK_DIV(DIV), .STABLE_CNT(STB),
    .LONG_CNT(LONG), .REPEAT_CNT(REP), .REPEAT_EN(0)
  ) dut_norep (
    .clk(clk), .reset_n(reset_n), .noise_btn(noise_btn),
    .clean_btn(clean1), .press_pulse(press1), .release_pulse(rel1),
    .long_pulse(long1), .repeat_pulse(rep1)
  );

  logic [5*NB-1:0] d_out [2];
  assign d_out[0] = {clean0, press0, rel0, long0, rep0};
  assign d_out[1] = {clean1, press1, rel1, long1, rep1};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: counts ticks since reset, ticks of disagreement, and ticks since press.
  int            m_div   [2];
  logic [NB-1:0] m_s1    [2];
  logic [NB-1:0] m_s2    [2];
  logic [NB-1:0] m_clean [2];
  int            m_diff  [2][NB];
  int            m_ticks [2][NB];
  logic [5*NB-1:0] m_out [2];
  bit            m_tick;
  logic [NB-1:0] pr, rl, lg, rp;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_div[k] = 0; m_s1[k] = '0; m_s2[k] = '0; m_clean[k] = '0; m_out[k] = '0;
        for (int c = 0; c < NB; c++) begin
          m_diff[k][c]  = 0;
          m_ticks[k][c] = -1;
        end
      end else begin
        m_tick = (m_div[k] == DIV - 1);
        pr = '0; rl = '0; lg = '0; rp = '0;
        for (int c = 0; c < NB; c++) begin
          if (m_tick) begin
            if (m_s2[k][c] != m_clean[k][c]) m_diff[k][c]++;
            else m_diff[k][c] = 0;
            if (m_diff[k][c] == STB) begin
              m_diff[k][c]  = 0;
              m_clean[k][c] = ~m_clean[k][c];
              if (m_clean[k][c]) begin pr[c] = 1'b1; m_ticks[k][c] = 0; end
              else begin rl[c] = 1'b1; m_ticks[k][c] = -1; end
            end else if (m_ticks[k][c] >= 0) begin
              m_ticks[k][c]++;
              if (m_ticks[k][c] == LONG) lg[c] = 1'b1;
              else if (k == 0 && m_ticks[k][c] > LONG && (m_ticks[k][c] - LONG) % REP == 0) rp[c] = 1'b1;
            end
          end
        end
        m_div[k] = m_tick ? 0 : m_div[k] + 1;
        m_s2[k]  = m_s1[k];
        m_s1[k]  = noise_btn;
        m_out[k] = {m_clean[k], pr, rl, lg, rp};
      end
    end
  end

  task automatic step();
    @(negedge clk);
    check("out_rep_en1", 32'(d_out[0]), 32'(m_out[0]));
    check("out_rep_en0", 32'(d_out[1]), 32'(m_out[1]));
  endtask

  int hold_left [NB];
  logic [NB-1:0] lvl;

  initial begin
    reset_n   = 1'b0;
    noise_btn = '0;
    @(negedge clk);
    step();
    check("reset_clean", 32'(clean0), 32'd0);
    reset_n = 1'b1;

    // Simultaneous press, long hold into repeat, release channel 1 only, then channel 0.
    noise_btn = 2'b11;
    repeat (150) step();
    noise_btn = 2'b01;
    repeat (80) step();
    noise_btn = 2'b00;
    repeat (60) step();

    // Short glitches on channel 0 that never reach the stable threshold.
    for (int g = 0; g < 40; g++) begin
      noise_btn[0] = ~noise_btn[0];
      repeat (5) step();
    end
    check("glitch_clean", 32'(clean0), 32'd0);

    // Held through a one-clk reset in the middle of auto-repeat.
    noise_btn = 2'b11;
    repeat (100) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (100) step();

    lvl = noise_btn;
    for (int c = 0; c < NB; c++) hold_left[c] = 0;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      for (int c = 0; c < NB; c++) begin
        if (hold_left[c] == 0) begin
          case ($urandom_range(0, 3))
            0, 1: begin lvl[c] = 1'($urandom_range(0, 1)); hold_left[c] = $urandom_range(20, 250); end
            2:    begin lvl[c] = ~lvl[c]; hold_left[c] = $urandom_range(1, 8); end
            default: begin lvl[c] = 1'b1; hold_left[c] = $urandom_range(100, 400); end
          endcase
        end
        hold_left[c]--;
      end
      noise_btn = lvl;
      reset_n   = !((cyc % 2500) == 1200 || $urandom_range(0, 1999) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/microwave_multi_btn_debounce.md
Name: microwave_multi_btn_debounce

Overview:
Parametrised N-channel pushbutton conditioner. It replaces per-button single-pulse debouncers on the microwave and air-conditioner front panels. Each channel has:
- a 2-FF synchroniser;
- a sample-tick integrating debounce filter;
- press/release edge pulses;
- long-press detection with optional auto-repeat, for time/temperature setting keys.

One shared prescaler drives all channels. Outputs feed the mode FSMs directly.

Parameters:
- NUM_BTN, 5, number of independent button channels (1..16).
- TICK_DIV, 100000, clk cycles per sample tick (100 MHz / 100000 = 1 kHz sample rate); must be ≥ 2.
- STABLE_CNT, 20, consecutive ticks the raw input must differ from the clean level before the clean level flips (20 ms).
- LONG_CNT, 1000, ticks the clean level must stay high, counted from its rise, before long_pulse fires (1 s).
- REPEAT_CNT, 200, ticks between auto-repeat pulses after long_pulse (200 ms).
- REPEAT_EN, 1, 1 enables auto-repeat; 0 gives a single long_pulse only.

Ports:
- clk, input, 1, 100 MHz system clock.
- reset_n, input, 1, synchronous active-low reset.
- noise_btn, input, NUM_BTN, raw asynchronous active-high buttons, one bit per channel.
- clean_btn, output, NUM_BTN, debounced level per channel.
- press_pulse, output, NUM_BTN, 1-clk pulse when clean_btn rises.
- release_pulse, output, NUM_BTN, 1-clk pulse when clean_btn falls.
- long_pulse, output, NUM_BTN, 1-clk pulse at long-press threshold.
- repeat_pulse, output, NUM_BTN, 1-clk auto-repeat pulse.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. Reset is sampled on the rising edge of clk when reset_n=0.
  - Clears the prescaler, synchronisers, stable counters, hold counters and per-channel FSMs.
  - All outputs are 0 from the first edge with reset_n=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly one clk when count == TICK_DIV-1.
  - First tick occurs TICK_DIV clks after reset release.
- Synchroniser: a 2-FF chain per channel, clocked every clk and not gated by tick. Its output is sync[i].
- Debounce filter, per channel, evaluated only on tick:
  - sync[i] != clean_btn[i]: stable counter +1. When the counter reaches STABLE_CNT, clean_btn[i] toggles and the counter clears in the same edge.
  - sync[i] == clean_btn[i]: stable counter clears.
  - Glitches shorter than STABLE_CNT ticks never change clean_btn.
  - Counter width is $clog2(STABLE_CNT+1).
- Edge pulses:
  - press_pulse[i]/release_pulse[i] are registered alongside clean_btn[i] on the same edge as the toggle.
  - Each is high exactly 1 clk, i.e. the tick cycle's following clk period.
- Per-channel FSM states: IDLE, PRESSED, LONG, REPEAT.
  - IDLE: clean_btn rises → PRESSED; hold counter = 0.
  - PRESSED: on each tick the hold counter +1. At LONG_CNT → long_pulse=1 for 1 clk; hold counter = 0; go to LONG if REPEAT_EN=1, else stay saturated in LONG with repeat disabled.
  - LONG (REPEAT_EN=1): on each tick the hold counter +1. At REPEAT_CNT → repeat_pulse=1 for 1 clk; hold counter = 0; go to REPEAT.
  - REPEAT: same counting. Emits repeat_pulse every REPEAT_CNT ticks indefinitely.
  - Any state: clean_btn falls → IDLE, hold counter cleared, no long/repeat pulse on that edge.
  - Hold counter width is $clog2(max(LONG_CNT,REPEAT_CNT)+1). It never wraps; it is cleared on every threshold hit.
- Channels are fully independent. Simultaneous presses on several channels produce pulses on the same clk for each, with no priority or masking.
- Per channel, at most one of press/release/long/repeat is high in any clk.
- Input held high through reset: after release it needs STABLE_CNT ticks, then gives a normal press_pulse. No pulse is generated at reset exit.
- Reset mid long-press: all state clears; a new press/long sequence starts from scratch.

Test Plan (params NUM_BTN=2, TICK_DIV=4, STABLE_CNT=3, LONG_CNT=10, REPEAT_CNT=4, unless stated):
1. Reset, then noise_btn[0] held 1 → clean_btn[0] rises on the 3rd tick after sync[0]=1; press_pulse[0]=1 for exactly 1 clk on that edge; channel 1 stays all-0.
2. noise_btn[0] toggling every 5 clks (glitch < 3 ticks) for 200 clks → clean_btn[0]=0 and no pulses throughout.
3. Hold btn[0] → long_pulse[0] 10 ticks after the press_pulse; repeat_pulse[0] at +14, +18 and +22 ticks. Release → release_pulse[0] 3 ticks after the input drops, then no further repeats.
4. REPEAT_EN=0, hold 30 ticks → exactly one long_pulse and zero repeat_pulse.
5. Both buttons pressed on the same clk → press_pulse=2'b11 on the same clk. Release btn1 only → release_pulse=2'b10; btn0's long/repeat timing unaffected.
6. reset_n=0 for 1 clk during REPEAT with the button still held → all outputs 0 on the next edge; press_pulse re-fires 3 ticks after the first post-reset tick; long_pulse 10 ticks after that.
